execute_stage: RTL

EXECUTE_STAGE -- requirements
Module: execute_stage

---
 rtl/execute_stage.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/execute_stage.sv
// Pipeline execute stage: ID/EX register, operand forwarding muxes, ALU and
// EX/MEM register. Stalls hold ID/EX and push a bubble into EX/MEM.
module execute_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        stalle,
  input  logic        flushe,
  input  logic [2:0]  alucontrold,
  input  logic        regwrited,
  input  logic        memtoregd,
  input  logic        memwrited,
  input  logic        alusrcd,
  input  logic        regdstd,
  input  logic [31:0] rd1d,
  input  logic [31:0] rd2d,
  input  logic [31:0] signimmd,
  input  logic [4:0]  rsd,
  input  logic [4:0]  rtd,
  input  logic [4:0]  rdd,
  input  logic [1:0]  forwardae,
  input  logic [1:0]  forwardbe,
  input  logic [31:0] resultw,
  output logic [4:0]  rse,
  output logic [4:0]  rte,
  output logic        regwritee,
  output logic        memtorege,
  output logic [4:0]  writerege,
  output logic        regwritem,
  output logic        memtoregm,
  output logic        memwritem,
  output logic        zerom,
  output logic [31:0] aluoutm,
  output logic [31:0] writedatam,
  output logic [4:0]  writeregm
);

  logic        r_regwritee, r_memtorege, r_memwritee, r_alusrce, r_regdste;
  logic [2:0]  r_alucontrole;
  logic [31:0] r_rd1e, r_rd2e, r_signimme;
  logic [4:0]  r_rse, r_rte, r_rde;

  logic        r_regwritem, r_memtoregm, r_memwritem, r_zerom;
  logic [31:0] r_aluoutm, r_writedatam;
  logic [4:0]  r_writeregm;

  logic [31:0] w_srcae, w_writedatae, w_srcbe, w_aluout;
  logic [4:0]  w_writerege;
  logic        w_zero;

  // ID/EX: flush beats stall
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_regwritee   <= 1'b0;
      r_memtorege   <= 1'b0;
      r_memwritee   <= 1'b0;
      r_alusrce     <= 1'b0;
      r_regdste     <= 1'b0;
      r_alucontrole <= 3'b0;
      r_rd1e        <= 32'h0;
      r_rd2e        <= 32'h0;
      r_signimme    <= 32'h0;
      r_rse         <= 5'h0;
      r_rte         <= 5'h0;
      r_rde         <= 5'h0;
    end else if (flushe) begin
      r_regwritee   <= 1'b0;
      r_memtorege   <= 1'b0;
      r_memwritee   <= 1'b0;
      r_alusrce     <= 1'b0;
      r_regdste     <= 1'b0;
      r_alucontrole <= 3'b0;
      r_rd1e        <= 32'h0;
      r_rd2e        <= 32'h0;
      r_signimme    <= 32'h0;
      r_rse         <= 5'h0;
      r_rte         <= 5'h0;
      r_rde         <= 5'h0;
    end else if (!stalle) begin
      r_regwritee   <= regwrited;
      r_memtorege   <= memtoregd;
      r_memwritee   <= memwrited;
      r_alusrce     <= alusrcd;
      r_regdste     <= regdstd;
      r_alucontrole <= alucontrold;
      r_rd1e        <= rd1d;
      r_rd2e        <= rd2d;
      r_signimme    <= signimmd;
      r_rse         <= rsd;
      r_rte         <= rtd;
      r_rde         <= rdd;
    end
  end

  // aluoutm forwarding reads the EX/MEM register, not the ALU output
  always_comb begin
    case (forwardae)
      2'b01:   w_srcae = resultw;
      2'b10:   w_srcae = r_aluoutm;
      default: w_srcae = r_rd1e;
    endcase
    case (forwardbe)
      2'b01:   w_writedatae = resultw;
      2'b10:   w_writedatae = r_aluoutm;
      default: w_writedatae = r_rd2e;
    endcase
  end

  assign w_srcbe     = r_alusrce ? r_signimme : w_writedatae;
  assign w_writerege = r_regdste ? r_rde : r_rte;

  always_comb begin
    case (r_alucontrole)
      3'b010:  w_aluout = w_srcae + w_srcbe;
      3'b110:  w_aluout = w_srcae - w_srcbe;
      3'b000:  w_aluout = w_srcae & w_srcbe;
      3'b001:  w_aluout = w_srcae | w_srcbe;
      3'b100:  w_aluout = w_srcae & ~w_srcbe;
      3'b101:  w_aluout = w_srcae | ~w_srcbe;
      3'b111:  w_aluout = {31'b0, ($signed(w_srcae) < $signed(w_srcbe))};
      default: w_aluout = 32'h0;
    endcase
  end

  assign w_zero = (w_aluout == 32'h0);

  // EX/MEM: a stalled EX instruction is held in ID/EX, so M gets a bubble
  // now and the real instruction on the next edge. With flush the EX
  // instruction leaves normally while ID/EX is cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_regwritem  <= 1'b0;
      r_memtoregm  <= 1'b0;
      r_memwritem  <= 1'b0;
      r_zerom      <= 1'b0;
      r_aluoutm    <= 32'h0;
      r_writedatam <= 32'h0;
      r_writeregm  <= 5'h0;
    end else if (stalle && !flushe) begin
      r_regwritem  <= 1'b0;
      r_memtoregm  <= 1'b0;
      r_memwritem  <= 1'b0;
      r_zerom      <= 1'b0;
      r_aluoutm    <= 32'h0;
      r_writedatam <= 32'h0;
      r_writeregm  <= 5'h0;
    end else begin
      r_regwritem  <= r_regwritee;
      r_memtoregm  <= r_memtorege;
      r_memwritem  <= r_memwritee;
      r_zerom      <= w_zero;
      r_aluoutm    <= w_aluout;
      r_writedatam <= w_writedatae;
      r_writeregm  <= w_writerege;
    end
  end

  assign rse        = r_rse;
  assign rte        = r_rte;
  assign regwritee  = r_regwritee;
  assign memtorege  = r_memtorege;
  assign writerege  = w_writerege;
  assign regwritem  = r_regwritem;
  assign memtoregm  = r_memtoregm;
  assign memwritem  = r_memwritem;
  assign zerom      = r_zerom;
  assign aluoutm    = r_aluoutm;
  assign writedatam = r_writedatam;
  assign writeregm  = r_writeregm;

endmodule
